// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer in the refclk domain: pulses the PLL reset, waits for a
// stable lock with timeout and retry budget, then releases the system reset.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic       lost_lock,
    output logic [3:0] retry_count
);

    localparam int CNT_MAX_VAL =
        (RST_CYCLES > LOCK_TIMEOUT)
            ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
            : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int CNT_W = (CNT_MAX_VAL > 1) ? $clog2(CNT_MAX_VAL) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0]             r_retry;
    logic                   r_pll_rst;
    logic                   r_sys_rst_n;
    logic                   r_ready;
    logic                   r_fault;
    logic                   r_lost_lock;

    state_t                 w_next_state;
    logic                   w_cnt_clear;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [3:0]             w_retry_next;
    logic                   w_lost_lock;
    logic                   w_locked_s;

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        w_next_state = r_state;
        w_cnt_clear  = 1'b0;
        w_retry_next = r_retry;
        w_lost_lock  = 1'b0;

        case (r_state)
            S_RESET_PLL: begin
                if (relock_req) begin
                    w_cnt_clear = 1'b1;
                end else if (r_cnt == RST_LAST) begin
                    w_next_state = S_WAIT_LOCK;
                end
            end

            S_WAIT_LOCK: begin
                // A lock seen on the timeout cycle takes priority over the retry.
                if (relock_req) begin
                    w_next_state = S_RESET_PLL;
                end else if (w_locked_s) begin
                    w_next_state = S_STABILIZE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    if (r_retry == RETRY_LIMIT) begin
                        w_next_state = S_FAULT;
                    end else begin
                        w_retry_next = r_retry + 4'd1;
                        w_next_state = S_RESET_PLL;
                    end
                end
            end

            S_STABILIZE: begin
                if (relock_req) begin
                    w_next_state = S_RESET_PLL;
                end else if (!w_locked_s) begin
                    w_next_state = S_WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_next_state = S_RUN;
                end
            end

            S_RUN: begin
                if (!w_locked_s) begin
                    w_lost_lock  = 1'b1;
                    w_retry_next = 4'd0;
                    w_next_state = S_RESET_PLL;
                end else if (relock_req) begin
                    w_retry_next = 4'd0;
                    w_next_state = S_RESET_PLL;
                end
            end

            S_FAULT: begin
                if (relock_req) begin
                    w_retry_next = 4'd0;
                    w_next_state = S_RESET_PLL;
                end
            end

            default: begin
                w_next_state = S_RESET_PLL;
            end
        endcase

        if (w_next_state != r_state) begin
            w_cnt_clear = 1'b1;
        end

        // Saturate rather than wrap so a long RUN/FAULT dwell never re-hits a compare value.
        if (w_cnt_clear) begin
            w_cnt_next = '0;
        end else if (r_cnt == {CNT_W{1'b1}}) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_state     <= S_RESET_PLL;
            r_cnt       <= '0;
            r_sync      <= '0;
            r_retry     <= 4'd0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
            r_lost_lock <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], pll_locked};
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_next;
            r_retry     <= w_retry_next;
            // Outputs decode the next state so they move on the same edge as the FSM.
            r_pll_rst   <= (w_next_state == S_RESET_PLL) || (w_next_state == S_FAULT);
            r_sys_rst_n <= (w_next_state == S_RUN);
            r_ready     <= (w_next_state == S_RUN);
            r_fault     <= (w_next_state == S_FAULT);
            r_lost_lock <= w_lost_lock;
        end
    end

    assign pll_rst     = r_pll_rst;
    assign sys_rst_n   = r_sys_rst_n;
    assign ready       = r_ready;
    assign fault       = r_fault;
    assign lost_lock   = r_lost_lock;
    assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: each scenario pushes the expected
// per-edge output vector, and a monitor pops and compares it after every edge.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic       lost_lock;
    logic [3:0] retry_count;

    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2),
        .SYNC_STAGES  (2)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fault      (fault),
        .lost_lock  (lost_lock),
        .retry_count(retry_count)
    );

    always #10 refclk = ~refclk;

    typedef struct {
        int         at;
        string      tag;
        logic [8:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Vector layout: {pll_rst, sys_rst_n, ready, fault, lost_lock, retry_count}
    function automatic logic [8:0] ov(input logic pr, input logic sr, input logic fl,
                                      input logic ll, input logic [3:0] rc);
        return {pr, sr, sr, fl, ll, rc};
    endfunction

    function automatic logic [8:0] v_rst(input logic [3:0] rc);   return ov(1, 0, 0, 0, rc); endfunction
    function automatic logic [8:0] v_idle(input logic [3:0] rc);  return ov(0, 0, 0, 0, rc); endfunction
    function automatic logic [8:0] v_run(input logic [3:0] rc);   return ov(0, 1, 0, 0, rc); endfunction
    function automatic logic [8:0] v_lost(input logic [3:0] rc);  return ov(1, 0, 0, 1, rc); endfunction
    function automatic logic [8:0] v_fault(input logic [3:0] rc); return ov(1, 0, 1, 0, rc); endfunction

    // Expect vector v after each of the next n edges, then advance n cycles.
    task automatic hold(input string tag, input int n, input logic [8:0] v);
        exp_t e;
        for (int i = 1; i <= n; i++) begin
            e.at  = cyc + i;
            e.tag = tag;
            e.v   = v;
            sb.push_back(e);
        end
        repeat (n) @(negedge refclk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge refclk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                check($sformatf("%s@%0d", e.tag, cyc),
                      {23'd0, pll_rst, sys_rst_n, ready, fault, lost_lock, retry_count},
                      {23'd0, e.v});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (2) @(negedge refclk);
        hold("reset", 2, v_rst(0));

        // Power-up with lock arriving on the 3rd WAIT_LOCK cycle.
        rst_n = 1'b1;
        hold("pu_pllrst", 3, v_rst(0));
        hold("pu_wait", 3, v_idle(0));
        pll_locked = 1'b1;
        hold("pu_lock", 10, v_idle(0));
        hold("pu_run", 3, v_run(0));

        // relock_req in RUN while locked: 4-cycle pll_rst, no lost_lock.
        relock_req = 1'b1;
        hold("rl_enter", 1, v_rst(0));
        relock_req = 1'b0;
        hold("rl_pllrst", 3, v_rst(0));
        hold("rl_acq", 9, v_idle(0));
        hold("rl_run", 2, v_run(0));

        // Loss of lock in RUN, then a one-cycle glitch during STABILIZE.
        pll_locked = 1'b0;
        hold("ll_delay", 2, v_run(0));
        hold("ll_pulse", 1, v_lost(0));
        hold("ll_pllrst", 3, v_rst(0));
        hold("ll_wait", 2, v_idle(0));
        pll_locked = 1'b1;
        hold("gl_stab", 5, v_idle(0));
        pll_locked = 1'b0;
        hold("gl_drop", 1, v_idle(0));
        pll_locked = 1'b1;
        hold("gl_restab", 10, v_idle(0));
        hold("gl_run", 2, v_run(0));

        // Never locks: retries exhaust into FAULT, relock_req recovers.
        pll_locked = 1'b0;
        hold("nl_delay", 2, v_run(0));
        hold("nl_pulse", 1, v_lost(0));
        hold("nl_rst0", 3, v_rst(0));
        hold("nl_wait0", 20, v_idle(0));
        hold("nl_rst1", 4, v_rst(1));
        hold("nl_wait1", 20, v_idle(1));
        hold("nl_rst2", 4, v_rst(2));
        hold("nl_wait2", 20, v_idle(2));
        hold("nl_fault", 5, v_fault(2));
        pll_locked = 1'b1;
        relock_req = 1'b1;
        hold("fr_enter", 1, v_rst(0));
        relock_req = 1'b0;
        hold("fr_pllrst", 3, v_rst(0));
        hold("fr_acq", 9, v_idle(0));
        hold("fr_run", 2, v_run(0));

        // Lock rises exactly on the WAIT_LOCK timeout cycle: lock wins, no retry.
        pll_locked = 1'b0;
        hold("to_delay", 2, v_run(0));
        hold("to_pulse", 1, v_lost(0));
        hold("to_pllrst", 3, v_rst(0));
        hold("to_wait", 18, v_idle(0));
        pll_locked = 1'b1;
        hold("to_edge", 10, v_idle(0));
        hold("to_run", 2, v_run(0));

        // Glitch with retry_count=1 (must be kept), then rst_n pulse in STABILIZE.
        pll_locked = 1'b0;
        hold("rs_delay", 2, v_run(0));
        hold("rs_pulse", 1, v_lost(0));
        hold("rs_rst0", 3, v_rst(0));
        hold("rs_wait0", 20, v_idle(0));
        hold("rs_rst1", 4, v_rst(1));
        hold("rs_wait1", 2, v_idle(1));
        pll_locked = 1'b1;
        hold("rs_stab", 5, v_idle(1));
        pll_locked = 1'b0;
        hold("rs_drop", 1, v_idle(1));
        pll_locked = 1'b1;
        hold("rs_restab", 3, v_idle(1));
        rst_n = 1'b0;
        hold("rs_reset", 1, v_rst(0));
        rst_n = 1'b1;
        hold("rs_pllrst", 3, v_rst(0));
        hold("rs_acq", 9, v_idle(0));
        hold("rs_run", 3, v_run(0));

        // rst_n pulse in RUN.
        rst_n = 1'b0;
        hold("rr_reset", 1, v_rst(0));
        rst_n = 1'b1;
        hold("rr_pllrst", 3, v_rst(0));
        hold("rr_acq", 9, v_idle(0));
        hold("rr_run", 3, v_run(0));

        @(posedge refclk);
        #2;
        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls the board PLL from the 50 MHz reference domain.
- Pulses the PLL reset after power-up and on request, waits for lock with a timeout and retry budget, and requires lock to be stable before releasing the system reset.
- On loss of lock, re-acquires automatically and flags a hard fault when the retries are exhausted.
- Sits between the PLL wrapper (drives its rst, reads its locked) and the SoC reset tree (its sys_rst_n feeds the 120 MHz-domain reset synchroniser).

Parameters:
- RST_CYCLES, 16, PLL reset pulse width in refclk cycles (≥1).
- LOCK_TIMEOUT, 50000, cycles allowed in WAIT_LOCK per attempt (1 ms at 50 MHz, ≥2).
- STABLE_CYCLES, 1024, cycles pll_locked must hold continuously before release (≥1).
- MAX_RETRIES, 3, timeouts tolerated per acquisition before FAULT (0..15).
- SYNC_STAGES, 2, flops in the pll_locked synchroniser (≥2).

Ports:
- refclk, input, 1, 50 MHz reference clock, the only clock.
- rst_n, input, 1, synchronous active-low reset.
- pll_locked, input, 1, PLL locked, asynchronous to refclk.
- relock_req, input, 1, single-cycle pulse: force a fresh PLL reset and acquisition.
- pll_rst, output, 1, active-high reset to the PLL.
- sys_rst_n, output, 1, active-low system reset, high only in RUN.
- ready, output, 1, high only in RUN.
- fault, output, 1, high only in FAULT.
- lost_lock, output, 1, one-cycle pulse when lock drops in RUN.
- retry_count, output, 4, timeouts in the current acquisition.

Behaviour:
- Synchroniser: locked_s is pll_locked through SYNC_STAGES flops. FSM decisions use only locked_s.
- Counters: one shared cycle counter, width $clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)). It clears on every state change and saturates, never wraps.
- Outputs: all registered, decoded from next-state, so they change on the same edge as the state.
- Reset (rst_n=0 at an edge): state=RESET_PLL, counter=0, retry_count=0, sync flops=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0, lost_lock=0. Applies from any state, including mid-acquisition and RUN.
- RESET_PLL: pll_rst=1. When counter==RST_CYCLES-1, go to WAIT_LOCK. pll_rst is high exactly RST_CYCLES cycles per entry.
- WAIT_LOCK: pll_rst=0.
  - locked_s=1: go to STABILIZE.
  - Otherwise, at counter==LOCK_TIMEOUT-1: if retry_count==MAX_RETRIES, go to FAULT; else retry_count+1 and go to RESET_PLL.
  - If the timeout and locked_s=1 land on the same cycle, locked_s wins.
- STABILIZE:
  - locked_s=0: return to WAIT_LOCK with counter cleared and no retry increment.
  - counter==STABLE_CYCLES-1 with locked_s=1: go to RUN.
- RUN: sys_rst_n=1, ready=1.
  - locked_s=0: lost_lock=1 for one cycle, retry_count cleared, go to RESET_PLL.
  - relock_req=1 with locked_s=1: go to RESET_PLL, retry_count cleared, no lost_lock pulse.
- FAULT: pll_rst=1, fault=1, sys_rst_n=0. Held until rst_n=0 or relock_req=1; relock_req clears retry_count and goes to RESET_PLL.
- relock_req in RESET_PLL, WAIT_LOCK or STABILIZE: restarts RESET_PLL with counter cleared; retry_count unchanged.
- Latency: sys_rst_n rises exactly SYNC_STAGES+STABLE_CYCLES edges after the first edge that samples pll_locked=1 in WAIT_LOCK.
- Release of sys_rst_n is never glitched: it stays low outside RUN.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2):
- Power-up with lock: rst_n released; pll_locked=1 from the 3rd cycle of WAIT_LOCK.
  → pll_rst high exactly 4 cycles; sys_rst_n and ready rise 10 edges after first sample; retry_count=0.
- Lock glitch: pll_locked drops 1 cycle in the middle of STABILIZE.
  → back to WAIT_LOCK; sys_rst_n stays 0; full 8-cycle stabilise restarts; retry_count unchanged.
- Never locks: pll_locked held 0.
  → three RESET_PLL pulses of 4 cycles; retry_count steps 0→1→2; FAULT after the 3rd 20-cycle timeout; fault=1, pll_rst=1.
  → then relock_req with pll_locked=1 reaches RUN; retry_count=0.
- Loss of lock in RUN: pll_locked falls.
  → lost_lock high exactly 1 cycle 2 edges later; sys_rst_n=0 and pll_rst=1 on the same edge; re-acquire completes normally.
- Reset mid-operation: rst_n=0 for 1 cycle during STABILIZE, then during RUN.
  → next edge shows reset values on every output; the sequence restarts from RESET_PLL.
- Simultaneous events: locked_s rises on the WAIT_LOCK timeout cycle → STABILIZE, no retry. relock_req in RUN while locked → 4-cycle pll_rst, lost_lock stays 0.
